// File: rtl/hamming_pkg.sv
// Shared definitions for the SECDED encoder and its two-requester arbiter.
//   DATA_W    : data word width (11)
//   CODE_W    : codeword width (16, extended Hamming)
//   req_id_t  : requester index type (0 or 1)
//   state_t   : output-slot occupancy state
//   even_parity : XOR reduction used for every parity bit
package hamming_pkg;

  localparam int DATA_W = 11;
  localparam int CODE_W = 16;

  typedef logic req_id_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Even parity over a 15-bit vector; the width covers the largest group.
  function automatic logic even_parity(input logic [14:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/hamming_encoder.sv
// Combinational 11-to-16 SECDED (extended Hamming) encoder.
// Codeword positions are numbered 1..16 and map to code[0]..code[15]:
//   positions 1/2/4/8 carry Hamming parity, position 16 carries overall parity,
//   the remaining positions carry data bits in ascending order.
// Ports:
//   data : input  [DATA_W-1:0] data word
//   code : output [CODE_W-1:0] SECDED codeword
module hamming_encoder
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [CODE_W-1:0] code
);

  logic p1;
  logic p2;
  logic p4;
  logic p8;

  // Each Hamming parity bit covers the data positions whose index has that bit set.
  always_comb begin
    p1 = even_parity({8'b0000_0000, data[0], data[1], data[3], data[4],
                      data[6], data[8], data[10]});
    p2 = even_parity({8'b0000_0000, data[0], data[2], data[3], data[5],
                      data[6], data[9], data[10]});
    p4 = even_parity({8'b0000_0000, data[1], data[2], data[3], data[7],
                      data[8], data[9], data[10]});
    p8 = even_parity({8'b0000_0000, data[4], data[5], data[6], data[7],
                      data[8], data[9], data[10]});
  end

  // Assemble the codeword; the overall parity bit covers positions 1..15.
  always_comb begin
    code          = {CODE_W{1'b0}};
    code[0]       = p1;
    code[1]       = p2;
    code[2]       = data[0];
    code[3]       = p4;
    code[6:4]     = data[3:1];
    code[7]       = p8;
    code[14:8]    = data[10:4];
    code[15]      = even_parity(code[14:0]);
  end

endmodule

// File: rtl/hamming_enc_arbiter.sv
// Two requesters share one SECDED encoder through a single-entry output slot.
// Parameter:
//   FAIR_RR : 1 = round-robin on ties, 0 = requester 0 always wins ties
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   req0_valid/data/ready : requester 0 handshake and 11-bit data word
//   req1_valid/data/ready : requester 1 handshake and 11-bit data word
//   out_valid/out_ready   : downstream handshake for the output slot
//   out_code              : 16-bit SECDED codeword held in the slot
//   out_id                : requester that produced out_code
//   enc_count             : number of accepted words, modulo 256
module hamming_enc_arbiter
  import hamming_pkg::*;
#(
  parameter int FAIR_RR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_id,
  output logic [7:0]        enc_count
);

  state_t              state_r;
  state_t              state_next_s;
  logic [CODE_W-1:0]   code_r;
  req_id_t             id_r;
  req_id_t             last_grant_r;
  logic [7:0]          count_r;

  req_id_t             grant_s;
  logic                slot_free_s;
  logic                accept_s;
  logic [DATA_W-1:0]   grant_data_s;
  logic [CODE_W-1:0]   enc_code_s;

  // Pick the requester to serve; data never influences the decision.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      if (FAIR_RR != 0) begin
        grant_s = ~last_grant_r;
      end else begin
        grant_s = 1'b0;
      end
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Handshake: the slot is free when empty or being drained this cycle.
  // Readies are forced low while reset is asserted so nothing is consumed.
  always_comb begin
    slot_free_s = (state_r == ST_EMPTY) || out_ready;
    accept_s    = rst_n && slot_free_s && (req0_valid || req1_valid);
    req0_ready  = accept_s && (grant_s == 1'b0);
    req1_ready  = accept_s && (grant_s == 1'b1);
  end

  // Granted-data mux feeding the single shared encoder.
  always_comb begin
    if (grant_s == 1'b1) begin
      grant_data_s = req1_data;
    end else begin
      grant_data_s = req0_data;
    end
  end

  hamming_encoder u_encoder (
    .data (grant_data_s),
    .code (enc_code_s)
  );

  // Slot occupancy next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          state_next_s = ST_FULL;
        end else begin
          state_next_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_ready && !accept_s) begin
          state_next_s = ST_EMPTY;
        end else begin
          state_next_s = ST_FULL;
        end
      end
      default: begin
        state_next_s = ST_EMPTY;
      end
    endcase
  end

  // State register; reset discards any held codeword.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Output slot, arbitration pointer and accept counter.
  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_r       <= {CODE_W{1'b0}};
      id_r         <= 1'b0;
      last_grant_r <= 1'b1;
      count_r      <= 8'd0;
    end else if (accept_s) begin
      code_r       <= enc_code_s;
      id_r         <= grant_s;
      last_grant_r <= grant_s;
      count_r      <= count_r + 8'd1;
    end else begin
      code_r       <= code_r;
      id_r         <= id_r;
      last_grant_r <= last_grant_r;
      count_r      <= count_r;
    end
  end

  assign out_valid = (state_r == ST_FULL);
  assign out_code  = code_r;
  assign out_id    = id_r;
  assign enc_count = count_r;

endmodule

// File: tb/tb_hamming_enc_arbiter.sv
// Directed bench for hamming_enc_arbiter with hand-computed SECDED codewords.
// Two instances share stimulus: u_rr (FAIR_RR=1) and u_fp (FAIR_RR=0).
module tb_hamming_enc_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic [10:0] req0_data;
  logic        req1_valid;
  logic [10:0] req1_data;
  logic        out_ready;

  logic        rr_req0_ready, rr_req1_ready, rr_out_valid, rr_out_id;
  logic [15:0] rr_out_code;
  logic [7:0]  rr_enc_count;
  logic        fp_req0_ready, fp_req1_ready, fp_out_valid, fp_out_id;
  logic [15:0] fp_out_code;
  logic [7:0]  fp_enc_count;

  int n_checks;
  int n_errors;

  hamming_enc_arbiter #(.FAIR_RR(1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(rr_req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(rr_req1_ready),
    .out_valid(rr_out_valid), .out_ready(out_ready), .out_code(rr_out_code),
    .out_id(rr_out_id), .enc_count(rr_enc_count)
  );

  hamming_enc_arbiter #(.FAIR_RR(0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(fp_req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(fp_req1_ready),
    .out_valid(fp_out_valid), .out_ready(out_ready), .out_code(fp_out_code),
    .out_id(fp_out_id), .enc_count(fp_enc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed codewords for requester-1-only vectors.
  logic [10:0] vec_data [3];
  logic [15:0] vec_code [3];

  initial begin
    n_checks = 0;
    n_errors = 0;
    vec_data[0] = 11'h7FF; vec_code[0] = 16'hFFFF;
    vec_data[1] = 11'h400; vec_code[1] = 16'hC08B;
    vec_data[2] = 11'h010; vec_code[2] = 16'h8181;

    // Reset with a requester asserted: nothing may be accepted.
    rst_n = 1'b0; out_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 11'h001;
    req1_valid = 1'b0; req1_data = 11'h000;
    tick();
    tick();
    check("rst_ready0", {15'd0, rr_req0_ready}, 16'd0);
    check("rst_valid", {15'd0, rr_out_valid}, 16'd0);
    check("rst_code", rr_out_code, 16'h0000);
    check("rst_id", {15'd0, rr_out_id}, 16'd0);
    check("rst_count", {8'd0, rr_enc_count}, 16'd0);

    // Single requester 0 word.
    rst_n = 1'b1;
    #1;
    check("t1_ready0", {15'd0, rr_req0_ready}, 16'd1);
    check("t1_ready1", {15'd0, rr_req1_ready}, 16'd0);
    tick();
    check("t1_valid", {15'd0, rr_out_valid}, 16'd1);
    check("t1_code", rr_out_code, 16'h8007);
    check("t1_id", {15'd0, rr_out_id}, 16'd0);
    check("t1_count", {8'd0, rr_enc_count}, 16'd1);

    // Drain without accept: slot empties, contents and counter hold.
    req0_valid = 1'b0;
    tick();
    check("drain_valid", {15'd0, rr_out_valid}, 16'd0);
    check("drain_code", rr_out_code, 16'h8007);
    check("drain_id", {15'd0, rr_out_id}, 16'd0);
    check("drain_count", {8'd0, rr_enc_count}, 16'd1);

    // Requester 1 alone, back-to-back words.
    for (int i = 0; i < 3; i++) begin
      req1_valid = 1'b1; req1_data = vec_data[i];
      #1;
      check("r1_ready1", {15'd0, rr_req1_ready}, 16'd1);
      check("r1_ready0", {15'd0, rr_req0_ready}, 16'd0);
      tick();
      check("r1_valid", {15'd0, rr_out_valid}, 16'd1);
      check("r1_code", rr_out_code, vec_code[i]);
      check("r1_id", {15'd0, rr_out_id}, 16'd1);
      check("r1_count", {8'd0, rr_enc_count}, 16'(2 + i));
    end
    req1_valid = 1'b0;

    // Fresh reset, then both requesters valid every cycle.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_data = 11'h000;
    req1_valid = 1'b1; req1_data = 11'h7FF;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_ready0", {15'd0, rr_req0_ready}, (i % 2 == 0) ? 16'd1 : 16'd0);
      check("rr_ready1", {15'd0, rr_req1_ready}, (i % 2 == 1) ? 16'd1 : 16'd0);
      check("fp_ready0", {15'd0, fp_req0_ready}, 16'd1);
      check("fp_ready1", {15'd0, fp_req1_ready}, 16'd0);
      tick();
      check("rr_valid", {15'd0, rr_out_valid}, 16'd1);
      check("rr_id", {15'd0, rr_out_id}, (i % 2 == 1) ? 16'd1 : 16'd0);
      check("rr_code", rr_out_code, (i % 2 == 1) ? 16'hFFFF : 16'h0000);
      check("rr_count", {8'd0, rr_enc_count}, 16'(i + 1));
      check("fp_id", {15'd0, fp_out_id}, 16'd0);
      check("fp_code", fp_out_code, 16'h0000);
      check("fp_count", {8'd0, fp_enc_count}, 16'(i + 1));
    end

    // Stall for 5 cycles with the slot full: everything holds.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_ready0", {15'd0, rr_req0_ready}, 16'd0);
      check("stall_ready1", {15'd0, rr_req1_ready}, 16'd0);
      tick();
      check("stall_valid", {15'd0, rr_out_valid}, 16'd1);
      check("stall_code", rr_out_code, 16'hFFFF);
      check("stall_id", {15'd0, rr_out_id}, 16'd1);
      check("stall_count", {8'd0, rr_enc_count}, 16'd4);
    end

    // Release: drain and accept requester 0 in the same cycle.
    out_ready = 1'b1;
    #1;
    check("rel_ready0", {15'd0, rr_req0_ready}, 16'd1);
    tick();
    check("rel_valid", {15'd0, rr_out_valid}, 16'd1);
    check("rel_code", rr_out_code, 16'h0000);
    check("rel_id", {15'd0, rr_out_id}, 16'd0);
    check("rel_count", {8'd0, rr_enc_count}, 16'd5);

    // Counter wrap: requester 0 alone until 256 words are accepted.
    req1_valid = 1'b0; req0_data = 11'h001;
    for (int i = 0; i < 250; i++) begin
      tick();
    end
    check("wrap_255", {8'd0, rr_enc_count}, 16'd255);
    tick();
    check("wrap_0", {8'd0, rr_enc_count}, 16'd0);
    check("wrap_valid", {15'd0, rr_out_valid}, 16'd1);
    check("wrap_code", rr_out_code, 16'h8007);

    // Reset while full: held codeword is discarded, no handshake.
    rst_n = 1'b0;
    #1;
    check("mrst_ready0", {15'd0, rr_req0_ready}, 16'd0);
    tick();
    check("mrst_valid", {15'd0, rr_out_valid}, 16'd0);
    check("mrst_count", {8'd0, rr_enc_count}, 16'd0);
    check("mrst_code", rr_out_code, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
